rr_quota_arbiter: RTL and testbench
===================================

# rr_quota_arbiter

Registered round-robin arbiter sharing one resource among N requesters, with an optional per-grant cycle quota that forces rotation when others are waiting. It replaces the fixed state-machine arbiter in front of the shared resource and presents the same req/gnt one-hot interface to requesters, plus an encoded owner index and a quota-expiry pulse.

## Interface
- N, 4: number of requesters; N ≥ 2
- QUOTA, 4: maximum consecutive grant cycles per owner while others are waiting; QUOTA ≥ 1
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- req  input  N  per-requester request level, held until the requester is served
- gnt  output  N  registered one-hot grant; all-zero when idle
- gnt_valid  output  1  registered; high when any gnt bit is set
- gnt_id  output  $clog2(N)  registered binary index of the current owner; 0 when idle
- quota_exp  output  1  registered one-cycle pulse; the current owner was pre-empted by quota

## Operation
- Reset (rst low, asynchronous): gnt=0, gnt_valid=0, gnt_id=0, quota_exp=0, state IDLE, rotate pointer ptr=0 (requester 0 has highest priority first), quota counter cnt=0.
- Round-robin pick: search req starting at ptr, wrapping modulo N; the first set bit wins. After a grant to i, ptr becomes (i+1) mod N, wrapping from N-1 to 0.
- FSM states: IDLE, GRANT.
- IDLE: if req≠0, pick the winner, load gnt/gnt_id, set cnt=1, go to GRANT; otherwise stay in IDLE with gnt=0.
- GRANT, owner o:
  - If req[o]=0: if another bit is set, grant the next pick in the following cycle (no idle gap) and set cnt=1. Otherwise go to IDLE and clear gnt.
  - If req[o]=1, cnt<QUOTA: hold the grant and increment cnt.
  - If req[o]=1, cnt=QUOTA, and other requests are pending: switch to the pick starting at (o+1) and pulse quota_exp=1 for that cycle.
  - If req[o]=1, cnt=QUOTA, and no other request is pending: hold the grant, cnt saturates at QUOTA, no pulse.
- A pre-empted owner whose req stays high re-enters arbitration in normal rotation order.
- Only one gnt bit is ever set. gnt_valid is the OR of gnt. gnt_id always matches gnt.
- cnt width is $clog2(QUOTA+1). It never wraps.

## Timing
- Latency: a req change sampled at edge k is reflected in gnt after edge k; the new value is visible in the cycle following k.
- Handoff: the old owner's gnt and the new owner's gnt never overlap. The changeover takes exactly one edge.
- Simultaneous requests in IDLE: the lowest index at or after ptr (modulo N) wins.
- Owner drops req in the same cycle its quota expires: treated as a normal release, with no quota_exp pulse.
- quota_exp is high for exactly one cycle, aligned with the first cycle of the new owner's grant.
- rst asserted mid-grant: all outputs clear immediately. After release, the first grant takes one edge from IDLE with ptr=0.

## Configuration
- ARB_QUOTA_EN defined: quota counter and pre-emption are implemented as described above.
- ARB_QUOTA_EN undefined: no counter. The owner holds the grant until its req drops. quota_exp is tied to 0. QUOTA is ignored.

## Structure
- Shared package arb_pkg holds:
  - the FSM state typedef (IDLE, GRANT)
  - default N and QUOTA constants
  - the one-hot-to-index function used for gnt_id
- One sub-module, rr_pick: combinational N-bit rotate-priority picker.
  - Inputs: req, ptr.
  - Outputs: one-hot winner and any-request flag.
  - The top instantiates it once. The top uses ptr=(o+1) mod N both on release and on pre-emption.

## Test plan
All scenarios use N=4, QUOTA=4, ARB_QUOTA_EN defined unless stated otherwise.
- Reset then req=0001: gnt=0000 during reset; gnt=0001 and gnt_id=0 one edge after req is sampled.
- Single requests in sequence 0001, 0010, 0100, 1000, 0000, each held 2 cycles: gnt follows with 1-cycle lag; gnt returns to 0000 and gnt_valid to 0 at the end.
- req=1111 held: grants rotate 0001→0010→0100→1000→0001, each owner held 4 cycles, with quota_exp pulsing at every change.
- req=0100 held alone for 10 cycles: gnt=0100 throughout; cnt saturates; quota_exp stays 0.
- Owner 1 releases while req=1010: the next cycle gnt=1000 with no idle gap. If 1 re-requests later with 3 pending, 3 is not skipped.
- rst pulsed low mid-grant (gnt=0010): outputs clear asynchronously. After release with req=1111, gnt=0001. Repeat with ARB_QUOTA_EN undefined: owner 0 is held indefinitely and quota_exp is never asserted.

Source files
------------

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin quota arbiter.
//   - arb_state_e   : arbiter FSM state (IDLE, GRANT)
//   - ARB_DEFAULT_N / ARB_DEFAULT_QUOTA : default requester count and quota
//   - onehot_to_idx : converts a one-hot vector (up to ARB_MAX_N bits) into
//                     its binary index; used to build gnt_id
// No ports (package).
// ----------------------------------------------------------------------------
package arb_pkg;

    localparam int ARB_DEFAULT_N     = 4;
    localparam int ARB_DEFAULT_QUOTA = 4;

    // Widest one-hot vector the index helper accepts, and its result width.
    localparam int ARB_MAX_N = 64;
    localparam int ARB_IDX_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Binary index of the set bit in a one-hot vector; 0 for an all-zero input.
    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage : arb_pkg

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority picker. Scans req_i starting at index ptr_i,
// wrapping modulo N, and returns the first set bit as a one-hot winner.
// Ports:
//   req_i [N-1:0]   request vector
//   ptr_i [IW-1:0]  index that has the highest priority this cycle
//   win_o [N-1:0]   one-hot winner (all-zero when no request)
//   any_o           high when any request bit is set
// ----------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter  int N  = ARB_DEFAULT_N,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  win_o,
    output logic          any_o
);

    logic          found;
    logic [IW-1:0] idx;

    // Walk the N positions in priority order; the first requester seen wins
    // and blocks every later position.
    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_i) + k) % N);
            if (!found && req_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule : rr_pick

// File: rtl/rr_quota_arbiter.sv
// ----------------------------------------------------------------------------
// rr_quota_arbiter
// Registered round-robin arbiter for N requesters with an optional per-grant
// cycle quota. When the quota feature is built in, an owner that has held the
// grant for QUOTA consecutive cycles is pre-empted if anyone else is waiting.
//
// Build option:
//   ARB_QUOTA_EN  defined   -> quota counter and pre-emption implemented
//                 undefined -> owner keeps the grant until its req drops,
//                              quota_exp is constant 0, QUOTA is ignored
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req  [N]   request levels, held until served
//   gnt  [N]   registered one-hot grant (0 when idle)
//   gnt_valid  registered OR of gnt
//   gnt_id     registered binary index of the owner (0 when idle)
//   quota_exp  registered one-cycle pulse on a quota pre-emption
// ----------------------------------------------------------------------------
module rr_quota_arbiter
    import arb_pkg::*;
#(
    parameter  int N     = ARB_DEFAULT_N,
    parameter  int QUOTA = ARB_DEFAULT_QUOTA,
    localparam int IW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id,
    output logic          quota_exp
);

    arb_state_e    state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic          valid_q, valid_d;
    logic          qexp_q, qexp_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  pick_win;
    logic          pick_any;
    logic [IW-1:0] win_idx;
    logic [IW-1:0] win_ptr_next;
    logic          owner_req;

`ifdef ARB_QUOTA_EN
    localparam int            CW   = $clog2(QUOTA + 1);
    localparam logic [CW-1:0] QMAX = CW'(QUOTA);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          others;

    assign others = |(req & ~gnt_q);
`else
    logic quota_unused;

    assign quota_unused = (QUOTA > 0);
`endif

    // While a grant is held ptr_q already equals (owner+1) mod N, so the single
    // picker instance serves IDLE arbitration, release handoff and quota
    // pre-emption alike: on pre-emption the still-requesting owner sits last
    // in the scan order and only wins if nobody else is asking.
    rr_pick #(
        .N (N)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    assign win_idx      = IW'(onehot_to_idx(ARB_MAX_N'(pick_win)));
    assign win_ptr_next = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
    assign owner_req    = |(req & gnt_q);

    // Next-state and next-output logic. Every branch that hands the resource
    // to a new owner loads the picker result and advances the rotate pointer.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        valid_d  = valid_q;
        qexp_d   = 1'b0;
        ptr_d    = ptr_q;
`ifdef ARB_QUOTA_EN
        cnt_d    = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = GRANT;
                    gnt_d    = pick_win;
                    gnt_id_d = win_idx;
                    valid_d  = 1'b1;
                    ptr_d    = win_ptr_next;
`ifdef ARB_QUOTA_EN
                    cnt_d    = CW'(1);
`endif
                end
            end

            GRANT: begin
                if (!owner_req) begin
                    // Owner released; a release at quota expiry is a plain
                    // release, so no pulse is raised here.
                    if (pick_any) begin
                        gnt_d    = pick_win;
                        gnt_id_d = win_idx;
                        valid_d  = 1'b1;
                        ptr_d    = win_ptr_next;
`ifdef ARB_QUOTA_EN
                        cnt_d    = CW'(1);
`endif
                    end else begin
                        state_d  = IDLE;
                        gnt_d    = '0;
                        gnt_id_d = '0;
                        valid_d  = 1'b0;
`ifdef ARB_QUOTA_EN
                        cnt_d    = '0;
`endif
                    end
                end else begin
`ifdef ARB_QUOTA_EN
                    // Count up to the quota; at the quota, rotate only if
                    // someone else is waiting, otherwise hold with the
                    // counter saturated.
                    if (cnt_q < QMAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end else if (others) begin
                        gnt_d    = pick_win;
                        gnt_id_d = win_idx;
                        valid_d  = 1'b1;
                        ptr_d    = win_ptr_next;
                        cnt_d    = CW'(1);
                        qexp_d   = 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                valid_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything asynchronously and
    // gives requester 0 the first chance after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            valid_q  <= 1'b0;
            qexp_q   <= 1'b0;
            ptr_q    <= '0;
`ifdef ARB_QUOTA_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            valid_q  <= valid_d;
            qexp_q   <= qexp_d;
            ptr_q    <= ptr_d;
`ifdef ARB_QUOTA_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_id    = gnt_id_q;
    assign quota_exp = qexp_q;

endmodule : rr_quota_arbiter

// File: tb/tb_rr_quota_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_quota_arbiter
// Directed self-checking bench for rr_quota_arbiter with N=4, QUOTA=4.
// Expectations follow whichever build is compiled (ARB_QUOTA_EN defined or
// not); scenarios whose outcome is the same in both builds are shared.
// ----------------------------------------------------------------------------
module tb_rr_quota_arbiter;

    localparam int N     = 4;
    localparam int QUOTA = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gntValid;
    logic [1:0] gntId;
    logic       quotaExp;

    int testsRun    = 0;
    int testsFailed = 0;

    rr_quota_arbiter #(
        .N     (N),
        .QUOTA (QUOTA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gntValid),
        .gnt_id    (gntId),
        .quota_exp (quotaExp)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive a request vector, let one rising edge sample it, then settle
    // 1 unit past the edge so outputs are read away from the clock.
    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] idxOf(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Checks the full output set against an expected grant and pulse.
    task automatic expectGrant(input string tag, input logic [3:0] expGnt, input logic expQexp);
        checkOutput({tag, ".gnt"},   32'(gnt),      32'(expGnt));
        checkOutput({tag, ".valid"}, 32'(gntValid), 32'(|expGnt));
        checkOutput({tag, ".id"},    32'(gntId),    32'(idxOf(expGnt)));
        checkOutput({tag, ".qexp"},  32'(quotaExp), 32'(expQexp));
    endtask

    // Main directed sequence; rotate-pointer values noted in comments are the
    // bench's own bookkeeping of where round-robin priority should sit.
    initial begin
        logic [3:0] seq [5];
        logic [3:0] expG;
        logic       expQ;

        seq[0] = 4'b0001;
        seq[1] = 4'b0010;
        seq[2] = 4'b0100;
        seq[3] = 4'b1000;
        seq[4] = 4'b0000;

        // Reset held with a request present: nothing may be granted.
        rst = 1'b0;
        req = 4'b0001;
        @(posedge clk);
        @(posedge clk);
        #1;
        expectGrant("rst_hold", 4'b0000, 1'b0);
        rst = 1'b1;
        applyStimulus(4'b0001);
        expectGrant("first_grant", 4'b0001, 1'b0);
        applyStimulus(4'b0000);
        expectGrant("first_release", 4'b0000, 1'b0);

        // Single requests in sequence, each held two cycles.
        for (int s = 0; s < 5; s++) begin
            for (int c = 0; c < 2; c++) begin
                applyStimulus(seq[s]);
                expectGrant($sformatf("single%0d_%0d", s, c), seq[s], 1'b0);
            end
        end

        // All four requesting: quota rotation (ptr starts at 0).
        for (int k = 0; k < 17; k++) begin
            applyStimulus(4'b1111);
`ifdef ARB_QUOTA_EN
            expG = 4'b0001 << ((k / QUOTA) % 4);
            expQ = (k > 0) && (k % QUOTA == 0);
`else
            expG = 4'b0001;
            expQ = 1'b0;
`endif
            expectGrant($sformatf("all%0d", k), expG, expQ);
        end
        applyStimulus(4'b0000);
        expectGrant("all_release", 4'b0000, 1'b0);

        // Lone requester held beyond the quota: no pre-emption, no pulse.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(4'b0100);
            expectGrant($sformatf("lone%0d", k), 4'b0100, 1'b0);
        end
        applyStimulus(4'b0000);
        expectGrant("lone_release", 4'b0000, 1'b0);

        // Owner 1 releases with 3 waiting: gapless handoff (ptr=3 here).
        applyStimulus(4'b0010);
        expectGrant("h_own1", 4'b0010, 1'b0);
        applyStimulus(4'b1010);
        expectGrant("h_wait3", 4'b0010, 1'b0);
        applyStimulus(4'b1000);
        expectGrant("h_to3", 4'b1000, 1'b0);
        applyStimulus(4'b1010);
        expectGrant("h_hold3", 4'b1000, 1'b0);
        applyStimulus(4'b0010);
        expectGrant("h_back1", 4'b0010, 1'b0);
        applyStimulus(4'b0000);
        expectGrant("h_idle", 4'b0000, 1'b0);

        // Simultaneous requests from IDLE with ptr=2: index 0 wraps in first.
        applyStimulus(4'b0011);
        expectGrant("wrap_pick", 4'b0001, 1'b0);
        applyStimulus(4'b0000);
        expectGrant("wrap_idle", 4'b0000, 1'b0);

        // Owner drops its request exactly at quota expiry: plain release.
        for (int k = 0; k < QUOTA; k++) begin
            applyStimulus(4'b0110);
            expectGrant($sformatf("drop_hold%0d", k), 4'b0010, 1'b0);
        end
        applyStimulus(4'b0100);
        expectGrant("drop_handoff", 4'b0100, 1'b0);
        applyStimulus(4'b0000);
        expectGrant("drop_idle", 4'b0000, 1'b0);

        // Reset asserted mid-grant, between clock edges (ptr=3 gives owner 1).
        applyStimulus(4'b0010);
        expectGrant("mid_own1", 4'b0010, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        expectGrant("mid_async_clr", 4'b0000, 1'b0);
        req = 4'b1111;
        @(posedge clk);
        #1;
        expectGrant("mid_rst_held", 4'b0000, 1'b0);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(4'b1111);
`ifdef ARB_QUOTA_EN
            expG = (k < QUOTA) ? 4'b0001 : 4'b0010;
            expQ = (k == QUOTA);
`else
            expG = 4'b0001;
            expQ = 1'b0;
`endif
            expectGrant($sformatf("post_rst%0d", k), expG, expQ);
        end
        applyStimulus(4'b0000);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule : tb_rr_quota_arbiter
